// File: rtl/freq_meter_pkg.sv
// Shared types and gate-length helpers for the multi-mode frequency meter.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_WAIT_EDGE,
    S_PERIOD,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic MODE_FREQ   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  localparam logic [1:0] GATE_1S    = 2'b00;
  localparam logic [1:0] GATE_100MS = 2'b01;
  localparam logic [1:0] GATE_10MS  = 2'b10;
  localparam logic [1:0] GATE_1MS   = 2'b11;

  function automatic int unsigned gate_scale(input logic [1:0] gs);
    case (gs)
      GATE_1S:    return 1;
      GATE_100MS: return 10;
      GATE_10MS:  return 100;
      GATE_1MS:   return 1000;
      default:    return 1;
    endcase
  endfunction

  function automatic int unsigned gate_cycles(input int unsigned clk_hz, input logic [1:0] gs);
    return clk_hz / gate_scale(gs);
  endfunction

endpackage

// File: rtl/fx_sync_edge.sv
// Multi-stage synchroniser for the measured pin plus a registered rising-edge strobe.
module fx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fx_in,
  output logic fx_sync,
  output logic fx_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  for (genvar gi = 0; gi < int'(SYNC_STAGES); gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = fx_in;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign fx_sync = sync_q[SYNC_STAGES-1];
  assign fx_rise = rise_q;

  // The strobe is registered, so a pin edge shows up SYNC_STAGES+1 clocks later.
  always_comb begin
    prev_d = fx_sync;
    rise_d = fx_sync & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

endmodule

// File: rtl/freq_meter_multi.sv
// Frequency / period meter: counts fx_in edges over a selectable gate, or system
// clocks across one fx_in period, with saturation and timeout reporting.
module freq_meter_multi
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = CLK_FREQ_HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fx_in,
  input  logic             start,
  input  logic             continuous,
  input  logic             mode,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             timeout
);

  // One timer serves as gate counter and timeout counter, so it is sized for the longer.
  localparam int unsigned     TIM_MAX  = (CLK_FREQ_HZ > TIMEOUT_CYC) ? CLK_FREQ_HZ : TIMEOUT_CYC;
  localparam int              TIM_W    = $clog2(TIM_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TIM_W-1:0] TMO_LAST = TIM_W'(TIMEOUT_CYC - 1);

  logic fx_rise;
  logic fx_sync_unused;

  fx_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fx_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .fx_in  (fx_in),
    .fx_sync(fx_sync_unused),
    .fx_rise(fx_rise)
  );

  logic [TIM_W-1:0] gate_last_tbl [4];
  logic [9:0]       scale_tbl     [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_gate_tbl
    assign gate_last_tbl[gi] = TIM_W'(gate_cycles(CLK_FREQ_HZ, 2'(gi)) - 1);
    assign scale_tbl[gi]     = 10'(gate_scale(2'(gi)));
  end

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [1:0]       gate_sel_q, gate_sel_d;
  logic [TIM_W-1:0] tim_cnt_q, tim_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [2*CNT_W-1:0] freq_prod;
  logic             arm;

  always_comb begin
    freq_prod      = (2*CNT_W)'(edge_cnt_q) * (2*CNT_W)'(scale_tbl[gate_sel_q]);
    state_d        = state_q;
    mode_d         = mode_q;
    gate_sel_d     = gate_sel_q;
    tim_cnt_d      = tim_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    clk_cnt_d      = clk_cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    timeout_d      = timeout_q;
    arm            = 1'b0;

    case (state_q)
      S_IDLE: arm = start;

      S_GATE: begin
        if (fx_rise && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + 1'b1;
        if (tim_cnt_q == gate_last_tbl[gate_sel_q]) state_d = S_CALC;
        else tim_cnt_d = tim_cnt_q + 1'b1;
      end

      S_WAIT_EDGE: begin
        if (fx_rise) begin
          state_d   = S_PERIOD;
          clk_cnt_d = CNT_W'(1);
          tim_cnt_d = TIM_W'(1);
        end else if (tim_cnt_q == TMO_LAST) begin
          state_d        = S_DONE;
          result_d       = '0;
          overflow_d     = 1'b0;
          timeout_d      = 1'b1;
          result_valid_d = 1'b1;
        end else begin
          tim_cnt_d = tim_cnt_q + 1'b1;
        end
      end

      // The closing edge cycle itself is not counted.
      S_PERIOD: begin
        if (fx_rise) begin
          state_d = S_CALC;
        end else if (tim_cnt_q == TMO_LAST) begin
          state_d        = S_DONE;
          result_d       = '0;
          overflow_d     = 1'b0;
          timeout_d      = 1'b1;
          result_valid_d = 1'b1;
        end else begin
          tim_cnt_d = tim_cnt_q + 1'b1;
          if (clk_cnt_q != CNT_MAX) clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_CALC: begin
        state_d        = S_DONE;
        result_valid_d = 1'b1;
        timeout_d      = 1'b0;
        if (mode_q == MODE_FREQ) begin
          if ((edge_cnt_q == CNT_MAX) || (freq_prod[2*CNT_W-1:CNT_W] != '0)) begin
            result_d   = CNT_MAX;
            overflow_d = 1'b1;
          end else begin
            result_d   = freq_prod[CNT_W-1:0];
            overflow_d = 1'b0;
          end
        end else begin
          result_d   = clk_cnt_q;
          overflow_d = (clk_cnt_q == CNT_MAX);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        arm     = continuous;
      end

      default: state_d = S_IDLE;
    endcase

    // Arming latches mode/gate_sel so later input changes cannot disturb a run.
    if (arm) begin
      mode_d     = mode;
      gate_sel_d = gate_sel;
      tim_cnt_d  = '0;
      edge_cnt_d = '0;
      clk_cnt_d  = '0;
      state_d    = (mode == MODE_PERIOD) ? S_WAIT_EDGE : S_GATE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mode_q         <= MODE_FREQ;
      gate_sel_q     <= GATE_1S;
      tim_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      clk_cnt_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      gate_sel_q     <= gate_sel_d;
      tim_cnt_q      <= tim_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      clk_cnt_q      <= clk_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/freq_meter_multi.md
Name: freq_meter_multi

Overview:
- Parametrised successor to the direct gated-count frequency meter. Everything runs in the system clock domain.
- The external signal fx_in is synchronised and edge-detected. It is not used as a clock.
- Two modes: frequency mode counts edges over a selectable gate; period mode counts system clocks across one input period.
- Results carry a valid pulse plus overflow and timeout flags. Sits between the signal input pin and the display/UART formatting logic.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency. Must be a multiple of 1000.
- CNT_W, 32, width of result and internal counters.
- SYNC_STAGES, 2, synchroniser flops on fx_in (minimum 2).
- TIMEOUT_CYC, CLK_FREQ_HZ, period-mode timeout in system clocks (1 s at default).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fx_in  in  1  asynchronous signal under measurement
- start  in  1  single-cycle request; sampled only in IDLE
- continuous  in  1  1 = re-arm automatically after each result
- mode  in  1  0 = frequency (result in Hz), 1 = period (result in system clocks)
- gate_sel  in  2  gate length: 00 = 1 s, 01 = 100 ms, 10 = 10 ms, 11 = 1 ms
- busy  out  1  high in any state other than IDLE
- result  out  CNT_W  last measurement; held until the next result
- result_valid  out  1  one-cycle pulse when result updates
- overflow  out  1  result was saturated; qualified by result_valid, held with result
- timeout  out  1  period measurement timed out; qualified by result_valid, held with result

Behaviour:
- Reset: result = 0, result_valid = 0, overflow = 0, timeout = 0, busy = 0, state = IDLE, synchroniser flops = 0.
- Reset mid-measurement aborts it and produces no result_valid.
- Edge detection:
  - fx_rise is asserted for one cycle when the synchronised fx_in goes 0->1.
  - Latency from a pin edge to fx_rise is SYNC_STAGES+1 clocks.
- start with mode/gate_sel: latched on the IDLE cycle where start = 1. Later changes have no effect until the next arm.
- Gate constants:
  - SCALE = 1, 10, 100, 1000 for gate_sel 00..11.
  - GATE_CYC = CLK_FREQ_HZ / SCALE.
- FSM states: IDLE, GATE, WAIT_EDGE, PERIOD, CALC, DONE.
  - IDLE: start & mode = 0 -> GATE. start & mode = 1 -> WAIT_EDGE. Counters cleared on exit.
  - GATE: gate counter runs 0..GATE_CYC-1. Every fx_rise during these cycles increments the edge count (the final cycle included). After the cycle at count GATE_CYC-1 -> CALC.
  - WAIT_EDGE: on fx_rise -> PERIOD with the clock count set to 1. If TIMEOUT_CYC clocks pass without an edge -> DONE with result = 0 and timeout = 1.
  - PERIOD: clock count increments each cycle. On the next fx_rise -> CALC, and that edge cycle is not counted; a 1 MHz input at 100 MHz gives exactly 100. Count reaching TIMEOUT_CYC -> DONE with timeout = 1 and result = 0.
  - CALC (1 cycle):
    - Frequency: result = edge count × SCALE, computed at 2·CNT_W width then saturated to 2^CNT_W−1; overflow = 1 if saturated.
    - Period: result = clock count.
  - DONE (1 cycle): result_valid = 1. Then -> GATE/WAIT_EDGE if continuous = 1, re-latching mode/gate_sel; otherwise -> IDLE.
- Counter saturation: the edge and clock counters saturate at 2^CNT_W−1 and never wrap. In frequency mode an edge counter that has saturated sets overflow.
- Result latency: frequency mode, result_valid occurs GATE_CYC+2 clocks after the IDLE start cycle.
- Continuous mode: the next gate begins the cycle after DONE. Back-to-back result_valid pulses are spaced GATE_CYC+2 clocks apart.
- start while busy is ignored. Clearing continuous mid-measurement takes effect at the next DONE.

Decomposition:
- Package freq_meter_pkg holds:
  - state enum
  - mode constants MODE_FREQ/MODE_PERIOD
  - gate_sel encodings
  - function gate_scale(gate_sel) returning 1/10/100/1000
  - function gate_cycles(clk_hz, gate_sel)
- One sub-module, fx_sync_edge: SYNC_STAGES synchroniser plus rising-edge detect, with outputs fx_sync and fx_rise.

Test Plan:
- Frequency, gate_sel = 11, 1 MHz fx_in (1000 ns period) -> result_valid after 100_002 clocks; result = 1_000_000, overflow = 0.
- Period, 1 MHz fx_in -> result = 100, timeout = 0. Same with 250 kHz -> result = 400.
- Period, fx_in held low, bench TIMEOUT_CYC = 5000 -> result_valid exactly 5001 clocks after start; result = 0, timeout = 1.
- CNT_W = 16, frequency, gate_sel = 11, 100 kHz fx_in (100 edges × 1000) -> result = 65535, overflow = 1.
- continuous = 1, gate_sel = 11, 2 MHz -> three consecutive pulses spaced 100_002 clocks apart, each result = 2_000_000. Dropping continuous returns to IDLE after the current result.
- rst asserted mid-GATE -> next cycle busy = 0, result = 0, no result_valid. A subsequent start measures correctly.
